// File: rtl/xif_cpu_offload_agent.sv
// CPU-side CORE-V-XIF initiator: offloads core instructions over the issue channel,
// tracks writeback IDs in a scoreboard and forwards results to the register-file port.
module xif_cpu_offload_agent #(
  parameter int X_NUM_RS        = 3,
  parameter int X_ID_WIDTH      = 4,
  parameter int X_RFR_WIDTH     = 32,
  parameter int X_RFW_WIDTH     = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            ck,
  input  logic                            rst,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  input  logic [31:0]                     instr,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] instr_rs,
  input  logic [X_NUM_RS-1:0]             instr_rs_valid,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [31:0]                     issue_instr,
  output logic [1:0]                      issue_mode,
  output logic [X_ID_WIDTH-1:0]           issue_id,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs,
  output logic [X_NUM_RS-1:0]             issue_rs_valid,
  input  logic                            issue_resp_accept,
  input  logic                            issue_resp_writeback,
  output logic                            offload_done,
  output logic                            offload_accepted,
  input  logic                            result_valid,
  output logic                            result_ready,
  input  logic [X_ID_WIDTH-1:0]           result_id,
  input  logic [X_RFW_WIDTH-1:0]          result_data,
  input  logic [4:0]                      result_rd,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [4:0]                      wb_rd,
  output logic [X_RFW_WIDTH-1:0]          wb_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                            err_unexpected_id
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int NID = 2 ** X_ID_WIDTH;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                      state_r, state_nxt;
  logic [X_ID_WIDTH-1:0]           next_id_r, next_id_nxt;
  logic [NID-1:0]                  scoreboard_r, scoreboard_nxt;
  logic [OW-1:0]                   outstanding_r, outstanding_nxt;
  logic                            instr_ready_r, instr_ready_nxt;
  logic                            issue_valid_r;
  logic [31:0]                     issue_instr_r;
  logic [X_ID_WIDTH-1:0]           issue_id_r;
  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_rs_r;
  logic [X_NUM_RS-1:0]             issue_rs_valid_r;
  logic                            offload_done_r;
  logic                            offload_accepted_r;
  logic                            wb_valid_r;
  logic [4:0]                      wb_rd_r;
  logic [X_RFW_WIDTH-1:0]          wb_data_r;
  logic                            err_r;

  logic capture, issue_hs, result_hs, result_hit, sb_set, sb_clr;

  assign capture    = instr_valid && instr_ready_r;
  assign issue_hs   = issue_valid_r && issue_ready;
  assign result_ready = !wb_valid_r || wb_ready;
  assign result_hs  = result_valid && result_ready;
  assign result_hit = scoreboard_r[result_id];
  assign sb_set     = issue_hs && issue_resp_accept && issue_resp_writeback;
  assign sb_clr     = result_hs && result_hit;

  // Next-state view; instr_ready is registered from it so a freed slot is usable the following cycle.
  always_comb begin
    state_nxt       = state_r;
    next_id_nxt     = next_id_r;
    scoreboard_nxt  = scoreboard_r;
    outstanding_nxt = outstanding_r;
    case (state_r)
      IDLE: begin
        if (capture) state_nxt = ISSUE;
        else         state_nxt = IDLE;
      end
      ISSUE: begin
        if (issue_hs) begin
          state_nxt = IDLE;
          if (issue_resp_accept) next_id_nxt = next_id_r + X_ID_WIDTH'(1);
          else                   next_id_nxt = next_id_r;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (sb_set) scoreboard_nxt[issue_id_r] = 1'b1;
    else        scoreboard_nxt = scoreboard_nxt;
    if (sb_clr) scoreboard_nxt[result_id] = 1'b0;
    else        scoreboard_nxt = scoreboard_nxt;
    case ({sb_set, sb_clr})
      2'b10:   outstanding_nxt = outstanding_r + OW'(1);
      2'b01:   outstanding_nxt = outstanding_r - OW'(1);
      default: outstanding_nxt = outstanding_r;
    endcase
    instr_ready_nxt = (state_nxt == IDLE) && (outstanding_nxt < MAX_OUT) &&
                      !scoreboard_nxt[next_id_nxt];
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_r            <= IDLE;
      next_id_r          <= '0;
      scoreboard_r       <= '0;
      outstanding_r      <= '0;
      instr_ready_r      <= 1'b0;
      issue_valid_r      <= 1'b0;
      issue_instr_r      <= 32'h0;
      issue_id_r         <= '0;
      issue_rs_r         <= '0;
      issue_rs_valid_r   <= '0;
      offload_done_r     <= 1'b0;
      offload_accepted_r <= 1'b0;
      wb_valid_r         <= 1'b0;
      wb_rd_r            <= 5'd0;
      wb_data_r          <= '0;
      err_r              <= 1'b0;
    end else begin
      state_r            <= state_nxt;
      next_id_r          <= next_id_nxt;
      scoreboard_r       <= scoreboard_nxt;
      outstanding_r      <= outstanding_nxt;
      instr_ready_r      <= instr_ready_nxt;
      offload_done_r     <= issue_hs;
      offload_accepted_r <= issue_hs && issue_resp_accept;
      err_r              <= result_hs && !result_hit;
      if (capture) begin
        issue_valid_r    <= 1'b1;
        issue_instr_r    <= instr;
        issue_id_r       <= next_id_r;
        issue_rs_r       <= instr_rs;
        issue_rs_valid_r <= instr_rs_valid;
      end else if (issue_hs) begin
        issue_valid_r    <= 1'b0;
      end else begin
        issue_valid_r    <= issue_valid_r;
      end
      // A new result may replace the write being retired in the same cycle.
      if (sb_clr) begin
        wb_valid_r <= 1'b1;
        wb_rd_r    <= result_rd;
        wb_data_r  <= result_data;
      end else if (wb_ready) begin
        wb_valid_r <= 1'b0;
      end else begin
        wb_valid_r <= wb_valid_r;
      end
    end
  end

  assign instr_ready       = instr_ready_r;
  assign issue_valid       = issue_valid_r;
  assign issue_instr       = issue_instr_r;
  assign issue_mode        = 2'b11;
  assign issue_id          = issue_id_r;
  assign issue_rs          = issue_rs_r;
  assign issue_rs_valid    = issue_rs_valid_r;
  assign offload_done      = offload_done_r;
  assign offload_accepted  = offload_accepted_r;
  assign wb_valid          = wb_valid_r;
  assign wb_rd             = wb_rd_r;
  assign wb_data           = wb_data_r;
  assign outstanding       = outstanding_r;
  assign err_unexpected_id = err_r;

endmodule

// File: doc/xif_cpu_offload_agent.md
Name: xif_cpu_offload_agent

Overview:
- CPU-side initiator of the CORE-V-XIF issue and result channels; the counterpart to the FPU's coprocessor-side ports.
- Takes instructions from a core-side request port and offloads them over issue, allocating an ID to each.
- Tracks outstanding writeback IDs in a scoreboard, receives results and forwards them to the integer register-file write port.
- Used in the core model and as the driving agent in FPU top-level benches.

Parameters:
- X_NUM_RS, 3, number of source operand ports.
- X_ID_WIDTH, 4, ID width; IDs are 0..2^X_ID_WIDTH-1.
- X_RFR_WIDTH, 32, source operand width.
- X_RFW_WIDTH, 32, writeback data width.
- MAX_OUTSTANDING, 4, maximum accepted-with-writeback instructions in flight; must be ≤ 2^X_ID_WIDTH.

Ports:
- ck  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr_valid  in  1  core has an instruction to offload.
- instr_ready  out  1  agent captured the instruction.
- instr  in  32  instruction word.
- instr_rs  in  X_NUM_RS*X_RFR_WIDTH  source operands, rs[0] in LSBs.
- instr_rs_valid  in  X_NUM_RS  operand validity.
- issue_valid  out  1  XIF issue_valid.
- issue_ready  in  1  XIF issue_ready.
- issue_instr  out  32  issue_req.instr.
- issue_mode  out  2  issue_req.mode; constant 2'b11.
- issue_id  out  X_ID_WIDTH  issue_req.id.
- issue_rs  out  X_NUM_RS*X_RFR_WIDTH  issue_req.rs.
- issue_rs_valid  out  X_NUM_RS  issue_req.rs_valid.
- issue_resp_accept  in  1  issue_resp.accept.
- issue_resp_writeback  in  1  issue_resp.writeback.
- offload_done  out  1  pulse: issue handshake finished.
- offload_accepted  out  1  accept value qualified by offload_done.
- result_valid  in  1  XIF result_valid.
- result_ready  out  1  XIF result_ready.
- result_id  in  X_ID_WIDTH  result.id.
- result_data  in  X_RFW_WIDTH  result.data.
- result_rd  in  5  result.rd.
- wb_valid  out  1  register-file write request.
- wb_ready  in  1  register file accepts the write.
- wb_rd  out  5  destination register.
- wb_data  out  X_RFW_WIDTH  write data.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of pending writeback IDs.
- err_unexpected_id  out  1  pulse: result carried an ID not in the scoreboard.

Behaviour:
- Reset values:
  - FSM = IDLE; next_id = 0; scoreboard = 0; outstanding = 0.
  - Outputs 0: issue_valid, instr_ready, offload_done, offload_accepted, wb_valid, err_unexpected_id.
  - issue_* data outputs 0.
- FSM IDLE:
  - instr_ready = 1 when can_issue; else 0.
  - can_issue = (outstanding < MAX_OUTSTANDING) && !scoreboard[next_id].
  - On instr_valid && instr_ready: capture instr/rs/rs_valid into issue_* registers, issue_id = next_id, go to ISSUE.
- FSM ISSUE:
  - issue_valid = 1; all issue_* outputs held stable until the handshake.
  - On issue_valid && issue_ready: offload_done = 1 for one cycle and offload_accepted = issue_resp_accept; go to IDLE.
  - If accept = 1 && writeback = 1: set scoreboard[issue_id] and increment outstanding.
  - If accept = 1: next_id increments modulo 2^X_ID_WIDTH.
  - If accept = 0: next_id is not advanced and the ID is reused.
  - issue_resp is sampled only in the handshake cycle.
- Issue throughput: at most one instruction every 2 cycles (capture, then issue).
- Result channel:
  - result_ready = !wb_valid || wb_ready (single-entry output register).
  - On result_valid && result_ready with scoreboard[result_id] = 1: clear the bit, decrement outstanding, and next cycle present wb_valid = 1 with wb_rd = result_rd, wb_data = result_data.
  - wb_valid holds until wb_ready.
  - On a handshake with an ID not in the scoreboard: err_unexpected_id pulses for 1 cycle, data is dropped, no wb_valid, and outstanding is unchanged.
- Simultaneous events:
  - Set and clear of outstanding in the same cycle: net change 0.
  - Scoreboard set and clear of the same ID in the same cycle is impossible: a pending ID blocks capture.
  - Clearing a bit at a full scoreboard permits capture in the following cycle, not the same cycle.
- ID wrap: 2^X_ID_WIDTH-1 → 0. If ID 0 is still pending, the agent stalls in IDLE with instr_ready = 0.
- Reset mid-operation: all state returns to reset values; a pending issue is abandoned and the wb register is cleared.

Test Plan:
- Single instruction: instr = 0x00A5_8553, accept = 1, writeback = 1, result with id 0 and data 0x4049_0FDB → wb_valid with wb_rd = 10, wb_data = 0x4049_0FDB; outstanding goes 0→1→0.
- issue_ready held low 5 cycles → issue_valid and all issue_* fields stable for 6 cycles; offload_done pulses once at the handshake.
- Reject: accept = 0 → offload_accepted = 0, the next instruction reuses id 0, outstanding stays 0.
- Four accepted writebacks with no results → outstanding = 4, instr_ready = 0; one result (id 2) → instr_ready = 1 on the next cycle, new issue_id = 4.
- Result with id 7 while the scoreboard is empty → err_unexpected_id 1-cycle pulse, no wb_valid; result with wb_ready held low → result_ready deasserts while wb_valid is pending.
- 20 accepted no-writeback issues → issue_id wraps 15→0. Assert rst during ISSUE → issue_valid = 0 and outstanding = 0 on the next cycle.
